// File: rtl/apb_master_bridge.sv
// APB requester: takes single read/write commands on a valid/ready port, runs the
// SETUP/ACCESS handshake against one slave and returns a one-cycle response pulse.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              P_clk,
  input  logic              P_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] P_addr,
  output logic              P_selx,
  output logic              P_enable,
  output logic              P_write,
  output logic [DATA_W-1:0] P_wdata,
  input  logic              P_ready,
  input  logic              P_slverr,
  input  logic [DATA_W-1:0] P_rdata
);

  // A zero TIMEOUT still needs a 1-bit counter so the declarations stay legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;

  function automatic logic timeout_hit(input logic [CNT_W-1:0] cnt);
    return (TIMEOUT != 0) && (cnt == TO_VAL);
  endfunction

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    wait_cnt_d    = wait_cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d    = cmd_addr;
          pwrite_d   = cmd_write;
          pwdata_d   = cmd_wdata;
          wait_cnt_d = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (P_ready) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = P_slverr;
          rsp_rdata_d = pwrite_q ? '0 : P_rdata;
          state_d     = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          if (timeout_hit(wait_cnt_d)) begin
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = '0;
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Select/enable are registered from the next state so they line up with the phase.
    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  always_ff @(posedge P_clk or posedge P_rst) begin
    if (P_rst) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      wait_cnt_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      wait_cnt_q    <= wait_cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign P_addr      = paddr_q;
  assign P_selx      = psel_q;
  assign P_enable    = penable_q;
  assign P_write     = pwrite_q;
  assign P_wdata     = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: a table of single transfers against a
// scripted slave, plus hand-written reset and pulse sequences.
module tb_apb_master_bridge;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              P_clk = 1'b0;
  logic              P_rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic [ADDR_W-1:0] P_addr;
  logic              P_selx;
  logic              P_enable;
  logic              P_write;
  logic [DATA_W-1:0] P_wdata;
  logic              P_ready;
  logic              P_slverr;
  logic [DATA_W-1:0] P_rdata;

  int tests = 0;
  int fails = 0;

  apb_master_bridge #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .P_clk      (P_clk),
    .P_rst      (P_rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .P_addr     (P_addr),
    .P_selx     (P_selx),
    .P_enable   (P_enable),
    .P_write    (P_write),
    .P_wdata    (P_wdata),
    .P_ready    (P_ready),
    .P_slverr   (P_slverr),
    .P_rdata    (P_rdata)
  );

  always #5 P_clk = ~P_clk;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;      // ACCESS cycles with P_ready low before ready (99 = never)
    logic        decoy;      // drive P_ready/P_slverr high during SETUP
    logic        slverr;
    logic [31:0] prdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_lat;    // cycles from accept edge to rsp_valid
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge P_clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   cycle;
    int   acc;
    int   n;
    logic got;
    logic hold_bad;
    logic setup_ok;
    logic access_ok;

    P_ready   = 1'b0;
    P_slverr  = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    n = 0;
    while (!cmd_ready && n < 50) begin
      next_cycle();
      n++;
    end
    next_cycle();
    // Keep a different command pending while busy; it must not be taken.
    cmd_addr  = ~v.addr;
    cmd_wdata = ~v.wdata;
    cmd_write = ~v.write;
    cycle     = 1;
    acc       = 0;
    got       = 1'b0;
    hold_bad  = 1'b0;
    setup_ok  = 1'b0;
    access_ok = 1'b0;
    while (!got && cycle < 40) begin
      if (rsp_valid) begin
        got = 1'b1;
        cmd_valid = 1'b0;
      end else begin
        if (cycle == 1) setup_ok = P_selx && !P_enable;
        if (cycle == 2) access_ok = P_selx && P_enable;
        if (P_addr !== v.addr || P_wdata !== v.wdata || P_write !== v.write ||
            cmd_ready !== 1'b0 || P_selx !== 1'b1)
          hold_bad = 1'b1;
        if (P_selx && P_enable) begin
          P_ready  = (acc >= v.waits);
          P_slverr = (acc >= v.waits) ? v.slverr : 1'b1;
          P_rdata  = (acc >= v.waits) ? v.prdata : 32'hBAD0_BAD0;
          acc++;
        end else begin
          P_ready  = v.decoy;
          P_slverr = v.decoy;
          P_rdata  = 32'hDEC0_DEC0;
        end
        next_cycle();
        cycle++;
      end
    end
    P_ready  = 1'b0;
    P_slverr = 1'b0;
    check($sformatf("v%0d rsp_seen", idx), got, 1'b1);
    check($sformatf("v%0d latency", idx), cycle, v.exp_lat);
    check($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
    check($sformatf("v%0d rsp_err", idx), rsp_err, v.exp_err);
    check($sformatf("v%0d rsp_timeout", idx), rsp_timeout, v.exp_to);
    check($sformatf("v%0d setup_phase", idx), setup_ok, 1'b1);
    check($sformatf("v%0d access_phase", idx), access_ok, 1'b1);
    check($sformatf("v%0d hold_while_busy", idx), hold_bad, 1'b0);
    check($sformatf("v%0d idle_sel_en", idx), {P_selx, P_enable}, 2'b00);
    check($sformatf("v%0d cmd_ready_at_rsp", idx), cmd_ready, 1'b1);
    check($sformatf("v%0d addr_held", idx), P_addr, v.addr);
    next_cycle();
    check($sformatf("v%0d pulse_clear", idx), {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    vec_t v;

    vecs[0] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 0,  1'b0, 1'b0, 32'h5555_5555, 32'h0,         1'b0, 1'b0, 3};
    vecs[1] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 0,  1'b0, 1'b0, 32'h0000_000C, 32'h0000_000C, 1'b0, 1'b0, 3};
    vecs[2] = '{1'b1, 32'h0000_0010, 32'hA5A5_0F0F, 4,  1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 7};
    vecs[3] = '{1'b0, 32'h0000_0020, 32'h1111_2222, 0,  1'b0, 1'b1, 32'h0000_1234, 32'h0000_1234, 1'b1, 1'b0, 3};
    vecs[4] = '{1'b0, 32'h0000_0024, 32'h3333_4444, 1,  1'b1, 1'b0, 32'h0000_0077, 32'h0000_0077, 1'b0, 1'b0, 4};
    vecs[5] = '{1'b0, 32'h0000_0030, 32'h5555_6666, 99, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b1, 18};
    vecs[6] = '{1'b1, 32'h0000_0034, 32'h7777_8888, 15, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 18};
    vecs[7] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 0,  1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 3};

    P_rst     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    P_ready   = 1'b0;
    P_slverr  = 1'b0;
    P_rdata   = '0;
    next_cycle();
    next_cycle();
    check("reset_outputs", {P_addr, P_wdata, P_selx, P_enable, P_write},
          {32'h0, 32'h0, 3'b000});
    check("reset_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {3'b000, 32'h0});
    check("reset_cmd_ready", cmd_ready, 1'b1);
    P_rst = 1'b0;
    next_cycle();

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      run_vec(i, v);
    end

    // Reset in the middle of an ACCESS cycle drops the transfer silently.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h0000_0040;
    cmd_wdata = 32'hCAFE_F00D;
    next_cycle();
    cmd_valid = 1'b0;
    next_cycle();
    check("pre_reset_access", {P_selx, P_enable, P_addr}, {2'b11, 32'h0000_0040});
    #3;
    P_rst = 1'b1;
    #1;
    check("async_reset_outputs", {P_addr, P_wdata, P_selx, P_enable, P_write, rsp_valid},
          {32'h0, 32'h0, 4'b0000});
    check("async_reset_ready", cmd_ready, 1'b1);
    next_cycle();
    P_rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid || P_selx) seen++;
      next_cycle();
    end
    check("no_rsp_after_reset", seen, 0);
    v = vecs[1];
    run_vec(8, v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
